postfix_eval: RTL and testbench
===============================

# postfix_eval

Sequential evaluator for NUL-terminated postfix expressions: single-digit operands, `+` and `*`. It consumes the packed postfix string that the infix-to-postfix converter produces and returns the integer value. It keeps its own operand stack in a register array and processes one character per clock. It closes the expression path: infix → postfix → value.

## Interface
- `LEN`, 16: maximum expression length in characters; bus is `8*LEN` bits.
- `W`, 16: result and operand-stack word width.
- `DEPTH`, 8: operand stack depth in entries; must be ≥ 2.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low (`rst` = 0 resets).
- `start`  in  1  request an evaluation; sampled only in IDLE.
- `postfix_expr`  in  8*LEN  ASCII, first character in bits `[8*LEN-1 -: 8]`, proceeding toward the LSB; `8'h00` terminates.
- `busy`  out  1  evaluation in progress.
- `done`  out  1  one-cycle pulse when `result`/`error` become valid.
- `result`  out  W  expression value modulo 2^W; 0 on error.
- `error`  out  1  evaluation failed.
- `err_code`  out  3  0 ok, 1 underflow, 2 overflow, 3 bad character, 4 leftover operands.

## Operation
- FSM states:
  - **IDLE**: on `start`, latch `postfix_expr` into an internal shift register, clear stack pointer `sp`, char index, `result`, `error` and `err_code`, then go to SCAN.
  - **SCAN**: each cycle examines the current top byte `c`, then shifts the register left by 8 and increments the index.
  - **IDLE** again after completion or abort (via the end check or error handling below).
- Actions in SCAN, by character:
  - `'0'..'9'`: if `sp == DEPTH`, overflow (code 2). Otherwise push `c - 8'h30`, zero-extended to W bits.
  - `'+'` / `'*'`: if `sp < 2`, underflow (code 1). Otherwise `stk[sp-2] <= stk[sp-2] op stk[sp-1]`, truncated to W bits, and `sp <= sp-1`. This is a single-cycle pop-pop-push.
  - Any other nonzero byte: bad character (code 3).
- End condition: `c == 0`, or all LEN characters consumed. Check `sp`:
  - `sp == 1`: `result <= stk[0]`, ok.
  - `sp == 0` (empty expression): underflow (code 1).
  - `sp > 1`: leftover operands (code 4).
- Error handling: abort on the offending character. Set `error = 1`, set `err_code`, set `result = 0`, pulse `done`, return to IDLE. Remaining characters are ignored.
- Output hold: `result`, `error` and `err_code` hold until the next accepted `start`.
- `start` is ignored while `busy`.
- Reset, asynchronous, including mid-evaluation: state IDLE, `sp = 0`, and `busy = done = error = 0`, `err_code = 0`, `result = 0`. The evaluation in progress is discarded and no `done` is emitted.

## Timing
- Edge numbering: E0 is the edge that samples `start` in IDLE. Character k (k = 0..N-1) is processed at edge E(k+1).
- Terminator or end condition is evaluated at E(N+1), or at E(LEN+1) when the string has no NUL.
- At that same edge: `busy` falls, `done` rises with `result`/`error`/`err_code` valid, and the FSM returns to IDLE. `done` falls at the next edge.
- Latency from `start` to `done`: N+1 cycles for a valid expression of N characters.
- Error abort at character k: `done` and `error` are registered at E(k+1).
- `busy` rises at E0.
- `start` held high while `done` is high is accepted at that edge (back-to-back operation); outputs clear at that edge.
- `postfix_expr` may change freely after E0.

## Test plan
- `"23+4*"`, W=16 → `done` at E6, `result` = 20, `error` = 0. Then `"234*+"` back-to-back → `result` = 14 at its E6.
- `"2+"` → `done` at E2, `error` = 1, `err_code` = 1, `result` = 0. Empty string (first byte 0) → `done` at E1, `err_code` = 1.
- `"23"` → `done` at E3, `err_code` = 4. `"2a3"` → `done` at E2, `err_code` = 3.
- DEPTH=2, `"123++"` → overflow at the third digit: `done` at E3, `err_code` = 2.
- W=8, `"99*9*"` → `result` = 217 (729 mod 256). A full LEN=16 string with no NUL → `done` at E17.
- Assert `rst` = 0 at E3 during `"23+4*"` → all outputs 0 immediately, no `done`. A new `start` after reset release evaluates correctly.

Source files
------------

// File: rtl/postfix_eval.sv
// Sequential postfix evaluator: single-digit operands, '+' and '*', one character per clock.
// Operands live in a small register stack; the result is taken modulo 2^W.
module postfix_eval #(
    parameter int LEN   = 16,
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8*LEN-1:0] postfix_expr,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             error,
    output logic [2:0]       err_code
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int IW  = $clog2(LEN + 1);

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_UNDER    = 3'd1;
    localparam logic [2:0] ERR_OVER     = 3'd2;
    localparam logic [2:0] ERR_BADCHAR  = 3'd3;
    localparam logic [2:0] ERR_LEFTOVER = 3'd4;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q;
    logic [8*LEN-1:0] shreg_q;
    logic [IW-1:0]    idx_q;
    logic [SPW-1:0]   sp_q;
    logic [W-1:0]     stk_q [DEPTH];
    logic             busy_q, done_q, error_q;
    logic [W-1:0]     result_q;
    logic [2:0]       code_q;

    logic [7:0]       c;
    logic             at_end, is_digit, is_op, is_mul, stk_full, stk_short;
    logic [AW-1:0]    top_a, nos_a, push_a;
    logic [W-1:0]     op_res_d;

    function automatic logic [W-1:0] digit_val(input logic [7:0] ch);
        return W'(ch[3:0]);
    endfunction

    function automatic logic [W-1:0] apply_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic mul);
        return mul ? a * b : a + b;
    endfunction

    assign c         = shreg_q[8*LEN-1 -: 8];
    assign at_end    = (c == 8'h00) || (idx_q == IW'(LEN));
    assign is_digit  = (c >= 8'h30) && (c <= 8'h39);
    assign is_mul    = (c == 8'h2A);
    assign is_op     = is_mul || (c == 8'h2B);
    assign stk_full  = (sp_q == SPW'(DEPTH));
    assign stk_short = (sp_q < SPW'(2));
    assign push_a    = AW'(sp_q);
    assign top_a     = AW'(sp_q - SPW'(1));
    assign nos_a     = AW'(sp_q - SPW'(2));
    assign op_res_d  = apply_op(stk_q[nos_a], stk_q[top_a], is_mul);

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign error    = error_q;
    assign err_code = code_q;

    // Control FSM and registered outputs; aborts return to IDLE with a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sp_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            code_q   <= ERR_OK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SCAN;
                        busy_q   <= 1'b1;
                        idx_q    <= '0;
                        sp_q     <= '0;
                        result_q <= '0;
                        error_q  <= 1'b0;
                        code_q   <= ERR_OK;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + IW'(1);
                    if (at_end) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (sp_q == SPW'(1)) begin
                            result_q <= stk_q[0];
                        end else begin
                            error_q <= 1'b1;
                            code_q  <= (sp_q == '0) ? ERR_UNDER : ERR_LEFTOVER;
                        end
                    end else if (is_digit && !stk_full) begin
                        sp_q <= sp_q + SPW'(1);
                    end else if (is_op && !stk_short) begin
                        sp_q <= sp_q - SPW'(1);
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        error_q  <= 1'b1;
                        result_q <= '0;
                        code_q   <= is_digit ? ERR_OVER : (is_op ? ERR_UNDER : ERR_BADCHAR);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath: character shift register and operand stack carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            shreg_q <= postfix_expr;
        end else if (state_q == SCAN) begin
            shreg_q <= shreg_q << 8;
        end
        if (state_q == SCAN && !at_end) begin
            if (is_digit && !stk_full) begin
                stk_q[push_a] <= digit_val(c);
            end else if (is_op && !stk_short) begin
                stk_q[nos_a] <= op_res_d;
            end
        end
    end
endmodule

// File: tb/tb_postfix_eval.sv
// Scoreboard bench for postfix_eval: a W=16/DEPTH=8 instance and a W=8/DEPTH=2 instance.
module tb_postfix_eval;
    localparam int LEN = 16;

    logic             clk, rst;
    logic             start_a, start_b;
    logic [8*LEN-1:0] expr_a, expr_b;
    logic             busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic [15:0]      result_a;
    logic [7:0]       result_b;
    logic [2:0]       err_code_a, err_code_b;

    typedef struct {
        int res;
        int err;
        int code;
        int at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   cyc;
    int   n_cmp, n_bad;

    postfix_eval #(.LEN(LEN), .W(16), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .postfix_expr(expr_a),
        .busy(busy_a), .done(done_a), .result(result_a), .error(error_a), .err_code(err_code_a)
    );

    postfix_eval #(.LEN(LEN), .W(8), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .postfix_expr(expr_b),
        .busy(busy_b), .done(done_b), .result(result_b), .error(error_b), .err_code(err_code_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8*LEN-1:0] pack(input string s);
        logic [8*LEN-1:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < LEN; i++) v[8*LEN-1-8*i -: 8] = s[i];
        return v;
    endfunction

    // Called just after a negedge; E0 is the next posedge.
    task automatic issue(input int which, input string s, input int res, input int err,
                         input int code, input int lat, input bit push);
        exp_t e;
        e.res  = res;
        e.err  = err;
        e.code = code;
        e.at   = cyc + 1 + lat;
        if (which == 0) begin
            start_a = 1'b1;
            expr_a  = pack(s);
            if (push) qa.push_back(e);
        end else begin
            start_b = 1'b1;
            expr_b  = pack(s);
            if (push) qb.push_back(e);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        expr_a  = '0;
        expr_b  = '0;
        chk({"busy_after_start ", s}, (which == 0) ? int'(busy_a) : int'(busy_b), 1);
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 60; i++) begin
            if (((which == 0) ? qa.size() : qb.size()) == 0) break;
            @(negedge clk);
            #1;
        end
        chk("pending_after_timeout", (which == 0) ? qa.size() : qb.size(), 0);
        if (which == 0) qa.delete();
        else qb.delete();
    endtask

    always @(negedge clk) begin
        if (rst && done_a) begin
            if (qa.size() == 0) begin
                chk("unexpected_done_a", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("done_cycle_a", cyc, ea.at);
                chk("result_a", int'(result_a), ea.res);
                chk("error_a", int'(error_a), ea.err);
                chk("err_code_a", int'(err_code_a), ea.code);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && done_b) begin
            if (qb.size() == 0) begin
                chk("unexpected_done_b", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("done_cycle_b", cyc, eb.at);
                chk("result_b", int'(result_b), eb.res);
                chk("error_b", int'(error_b), eb.err);
                chk("err_code_b", int'(err_code_b), eb.code);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        expr_a  = '0;
        expr_b  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_done_a", int'(done_a), 0);
        chk("rst_result_a", int'(result_a), 0);
        chk("rst_error_a", int'(error_a), 0);
        chk("rst_code_a", int'(err_code_a), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        chk("rst_result_b", int'(result_b), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;

        issue(0, "23+4*", 20, 0, 0, 6, 1);
        wait_done(0);
        issue(0, "234*+", 14, 0, 0, 6, 1);
        wait_done(0);
        chk("hold_result_a", int'(result_a), 14);
        issue(0, "2+", 0, 1, 1, 2, 1);
        wait_done(0);
        issue(0, "", 0, 1, 1, 1, 1);
        wait_done(0);
        issue(0, "23", 0, 1, 4, 3, 1);
        wait_done(0);
        issue(0, "2a3", 0, 1, 3, 2, 1);
        wait_done(0);
        issue(0, "12+3+4+5+6+7+8+9", 0, 1, 4, 17, 1);
        wait_done(0);
        issue(0, "99*9*", 729, 0, 0, 6, 1);
        wait_done(0);

        issue(1, "123++", 0, 1, 2, 3, 1);
        wait_done(1);
        issue(1, "99*9*", 217, 0, 0, 6, 1);
        wait_done(1);
        issue(1, "12+", 3, 0, 0, 4, 1);
        wait_done(1);

        issue(0, "23+4*", 0, 0, 0, 6, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_done", int'(done_a), 0);
        chk("midrst_result", int'(result_a), 0);
        chk("midrst_error", int'(error_a), 0);
        chk("midrst_code", int'(err_code_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        issue(0, "34*5+", 17, 0, 0, 6, 1);
        wait_done(0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
